reg_file_8x4: RTL and testbench
===============================

REG_FILE_8X4 -- requirements
Module: reg_file_8x4

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating write-collision counter (legal 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: we  input  1  global write strobe; gates all per-register enables.
REQ-005 Port: d  input  4 x [7:0] unpacked  per-register write data from the two-write-port stage.
REQ-006 Port: enable  input  1 x [7:0] unpacked  per-register write enables from the two-write-port stage.
REQ-007 Port: wr_addr_1, wr_addr_2  input  3 each  raw write addresses, used only for collision detection.
REQ-008 Port: rd_en  input  1  read request for both read ports.
REQ-009 Port: rd_addr_1, rd_addr_2  input  3 each  read addresses.
REQ-010 Port: rd_data_1, rd_data_2  output  4 each  registered read data.
REQ-011 Port: rd_valid  output  1  high for one cycle when rd_data_* are updated.
REQ-012 Port: dirty  output  8  bit i set once register i has been written since reset or clear.
REQ-013 Port: clr  input  1  synchronous clear of dirty and coll_cnt; register contents are kept.
REQ-014 Port: coll_cnt  output  CNT_W  saturating count of same-address dual writes.

Function
REQ-015 Storage: eight 4-bit registers r[0..7].
REQ-016 Write: on each rising edge, r[i] <= d[i] iff we && enable[i]; independent per register; multiple registers may be written in one cycle.
REQ-017 Write with we=0: no register changes, regardless of enable.
REQ-018 Read: when rd_en=1, rd_data_1 <= r[rd_addr_1] and rd_data_2 <= r[rd_addr_2] at the next edge; 1-cycle latency; rd_valid <= 1 in that same edge.
REQ-019 Read with rd_en=0: rd_data_* hold previous values; rd_valid <= 0.
REQ-020 Both read ports may address the same register; both return identical data.
REQ-021 Dirty: dirty[i] <= 1 on any edge where we && enable[i]; cleared to 0 by clr.
REQ-022 Collision: on an edge where we=1 and wr_addr_1 == wr_addr_2, coll_cnt increments by 1 and saturates at 2^CNT_W - 1 (no wrap).
REQ-023 clr and write in the same cycle: clr wins for coll_cnt (result 0); for dirty, the write wins (dirty[i] = 1 for the written register, all others 0).
REQ-024 Read-during-write of the same register: behaviour selected by REQ-029/REQ-030.

Reset
REQ-025 rst_n low clears r[0..7] to 4'h0 asynchronously.
REQ-026 rst_n low clears rd_data_1, rd_data_2 to 4'h0 and rd_valid to 0.
REQ-027 rst_n low clears dirty to 8'h00 and coll_cnt to 0.
REQ-028 rst_n asserted mid-read or mid-write discards the operation; the first edge after deassertion is processed normally.

Configuration
REQ-029 With macro REG_FILE_BYPASS_EN defined, a read of register i in a cycle where we && enable[i] returns d[i] (write-first).
REQ-030 Without REG_FILE_BYPASS_EN, the same read returns the pre-write contents of r[i] (read-first); no bypass logic is present.

Verification
REQ-031 Reset, then rd_en=1 with rd_addr_1=0 and rd_addr_2=7 -> next cycle rd_data_1=0, rd_data_2=0, rd_valid=1, dirty=8'h00, coll_cnt=0.
REQ-032 we=1, enable[3]=1, d[3]=4'hA, enable[5]=1, d[5]=4'h6; next cycle read addr 3 and 5 -> rd_data_1=4'hA, rd_data_2=4'h6, dirty=8'h28.
REQ-033 we=0, enable=8'hFF, d[*]=4'hF -> contents unchanged, dirty unchanged.
REQ-034 r[2]=4'h1; same cycle we=1, enable[2]=1, d[2]=4'h9, rd_en=1, rd_addr_1=2 -> rd_data_1=4'h9 with REG_FILE_BYPASS_EN, 4'h1 without; r[2]=4'h9 afterwards in both builds.
REQ-035 CNT_W=2; 5 cycles of we=1, wr_addr_1=wr_addr_2=4 -> coll_cnt 1,2,3,3,3; then clr=1 -> coll_cnt=0, dirty=0, r[4] unchanged.
REQ-036 Write r[6]=4'hC, assert rst_n low asynchronously between edges -> r[6], rd_data_*, dirty, coll_cnt read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_8x4.sv
// reg_file_8x4 -- eight 4-bit registers with per-register write enables,
// two registered read ports, dirty tracking and a saturating counter of
// same-address dual writes.
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   rst_n                 asynchronous active-low reset
//   we                    global write strobe, gates every per-register enable
//   d[8]                  per-register 4-bit write data
//   enable[8]             per-register write enables
//   wr_addr_1, wr_addr_2  raw write addresses, used only for collision counting
//   rd_en                 read request for both read ports
//   rd_addr_1, rd_addr_2  read addresses
//   rd_data_1, rd_data_2  registered read data (1-cycle latency)
//   rd_valid              high for one cycle when rd_data_* are updated
//   dirty                 bit i set once register i is written since reset/clr
//   clr                   synchronous clear of dirty and coll_cnt
//   coll_cnt              saturating count of same-address dual writes
//
// Build option:
//   REG_FILE_BYPASS_EN    when defined, a read of a register being written in
//                         the same cycle returns the incoming data
//                         (write-first); otherwise the pre-write contents are
//                         returned (read-first) and no bypass mux exists.

module reg_file_8x4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       d [8],
    input  logic             enable [8],
    input  logic [2:0]       wr_addr_1,
    input  logic [2:0]       wr_addr_2,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr_1,
    input  logic [2:0]       rd_addr_2,
    output logic [3:0]       rd_data_1,
    output logic [3:0]       rd_data_2,
    output logic             rd_valid,
    output logic [7:0]       dirty,
    input  logic             clr,
    output logic [CNT_W-1:0] coll_cnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [3:0] r [8];
    logic [7:0] wr_mask;
    logic [3:0] rd_word_1_p0;
    logic [3:0] rd_word_2_p0;
    logic       coll_p0;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < 8; i++) begin
            wr_mask[i] = we & enable[i];
        end
    end

    assign coll_p0 = we && (wr_addr_1 == wr_addr_2);

`ifdef REG_FILE_BYPASS_EN
    // Forward the incoming write data when the addressed register is
    // being written on this same edge.
    assign rd_word_1_p0 = wr_mask[rd_addr_1] ? d[rd_addr_1] : r[rd_addr_1];
    assign rd_word_2_p0 = wr_mask[rd_addr_2] ? d[rd_addr_2] : r[rd_addr_2];
`else
    assign rd_word_1_p0 = r[rd_addr_1];
    assign rd_word_2_p0 = r[rd_addr_2];
`endif

    // ---- stage p0 -> p1: storage, read port, tracking ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) begin
                    r[i] <= d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_1 <= 4'h0;
            rd_data_2 <= 4'h0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_1 <= rd_word_1_p0;
                rd_data_2 <= rd_word_2_p0;
            end
        end
    end

    // clr drops history, but a write on the same edge still marks its
    // register dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= 8'h00;
        end else if (clr) begin
            dirty <= wr_mask;
        end else begin
            dirty <= dirty | wr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (clr) begin
            coll_cnt <= '0;
        end else if (coll_p0) begin
            coll_cnt <= sat_inc(coll_cnt);
        end
    end

endmodule

// File: tb/tb_reg_file_8x4.sv
module tb_reg_file_8x4;

    localparam int CW = 2;
    localparam int COLL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [3:0]    d [8];
    logic          enable [8];
    logic [2:0]    wr_addr_1, wr_addr_2;
    logic          rd_en;
    logic [2:0]    rd_addr_1, rd_addr_2;
    logic [3:0]    rd_data_1, rd_data_2;
    logic          rd_valid;
    logic [7:0]    dirty;
    logic          clr;
    logic [CW-1:0] coll_cnt;

    reg_file_8x4 #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .d(d), .enable(enable),
        .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2), .rd_en(rd_en),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .rd_valid(rd_valid),
        .dirty(dirty), .clr(clr), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    r1;
        logic [3:0]    r2;
        logic [7:0]    dirty;
        logic [CW-1:0] coll;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   mem [8];
    int   m_dirty;
    int   m_coll;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per valid read response.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rd_data_1", int'(rd_data_1), int'(e.r1));
                check("rd_data_2", int'(rd_data_2), int'(e.r2));
                check("dirty", int'(dirty), int'(e.dirty));
                check("coll_cnt", int'(coll_cnt), int'(e.coll));
            end
        end
    end

    function automatic int model_read(input int a);
`ifdef REG_FILE_BYPASS_EN
        if (we && enable[a]) return int'(d[a]);
`endif
        return mem[a];
    endfunction

    // Apply current inputs for one clock edge, updating the model.
    task automatic step();
        exp_t e;
        int   v1, v2, mask;
        v1 = model_read(int'(rd_addr_1));
        v2 = model_read(int'(rd_addr_2));
        mask = 0;
        for (int i = 0; i < 8; i++) begin
            if (we && enable[i]) begin
                mem[i] = int'(d[i]);
                mask |= (1 << i);
            end
        end
        m_dirty = clr ? mask : (m_dirty | mask);
        if (clr) m_coll = 0;
        else if (we && wr_addr_1 == wr_addr_2 && m_coll < COLL_MAX) m_coll++;
        if (rd_en) begin
            e.r1 = 4'(v1); e.r2 = 4'(v2);
            e.dirty = 8'(m_dirty); e.coll = CW'(m_coll);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; rd_en = 0; clr = 0;
        wr_addr_1 = 3'd0; wr_addr_2 = 3'd1;
        rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'h0; enable[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = 0;
        m_dirty = 0; m_coll = 0;
    endtask

    task automatic do_read(input logic [2:0] a1, input logic [2:0] a2);
        idle_inputs();
        rd_en = 1; rd_addr_1 = a1; rd_addr_2 = a2;
        step();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data_1", int'(rd_data_1), 0);
        check("reset_rd_data_2", int'(rd_data_2), 0);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_dirty", int'(dirty), 0);
        check("reset_coll_cnt", int'(coll_cnt), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Read after reset: addresses 0 and 7 are zero
        do_read(3'd0, 3'd7);

        // Two registers written in one cycle, then read back
        idle_inputs();
        we = 1; enable[3] = 1; d[3] = 4'hA; enable[5] = 1; d[5] = 4'h6;
        step();
        do_read(3'd3, 3'd5);

        // we=0 with all enables: nothing changes
        idle_inputs();
        for (int i = 0; i < 8; i++) begin enable[i] = 1; d[i] = 4'hF; end
        step();
        do_read(3'd3, 3'd5);
        do_read(3'd5, 3'd5);

        // Read-during-write of the same register
        idle_inputs();
        we = 1; enable[2] = 1; d[2] = 4'h1; enable[4] = 1; d[4] = 4'h5;
        step();
        idle_inputs();
        we = 1; enable[2] = 1; d[2] = 4'h9; rd_en = 1; rd_addr_1 = 3'd2; rd_addr_2 = 3'd4;
        step();
        do_read(3'd2, 3'd2);

        // Collision counter saturation (CW=2), then clear
        idle_inputs(); clr = 1; step();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            we = 1; wr_addr_1 = 3'd4; wr_addr_2 = 3'd4;
            rd_en = 1; rd_addr_1 = 3'd4; rd_addr_2 = 3'd3;
            step();
        end
        idle_inputs(); clr = 1; rd_en = 1; rd_addr_1 = 3'd4; rd_addr_2 = 3'd2;
        step();
        do_read(3'd4, 3'd2);

        // clr together with a colliding write
        idle_inputs(); we = 1; enable[0] = 1; d[0] = 4'h3; step();
        idle_inputs();
        clr = 1; we = 1; enable[1] = 1; d[1] = 4'h7; wr_addr_1 = 3'd4; wr_addr_2 = 3'd4;
        step();
        do_read(3'd1, 3'd0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            wr_addr_1 = 3'($urandom_range(0, 7));
            wr_addr_2 = ($urandom_range(0, 2) == 0) ? wr_addr_1 : 3'($urandom_range(0, 7));
            rd_addr_1 = 3'($urandom_range(0, 7));
            rd_addr_2 = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                d[i] = 4'($urandom_range(0, 15));
                enable[i] = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        idle_inputs();
        step();
        step();
        check("queue_drained", q.size(), 0);

        // Asynchronous reset between edges
        idle_inputs(); clr = 1; step();
        idle_inputs();
        we = 1; enable[6] = 1; d[6] = 4'hC; wr_addr_1 = 3'd2; wr_addr_2 = 3'd2;
        step();
        do_read(3'd6, 3'd6);
        idle_inputs();
        #6;
        check("pre_reset_rd_data_1", int'(rd_data_1), 'hC);
        rst_n = 0;
        #1;
        check("async_rd_data_1", int'(rd_data_1), 0);
        check("async_rd_data_2", int'(rd_data_2), 0);
        check("async_rd_valid", int'(rd_valid), 0);
        check("async_dirty", int'(dirty), 0);
        check("async_coll_cnt", int'(coll_cnt), 0);
        q.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        do_read(3'd6, 3'd0);
        idle_inputs();
        step();
        check("final_queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
